ex_muldiv: RTL

//  Iterative RV64M multiply/divide unit in the EX stage. Takes operands and rd from the ID/EX register outputs.

---
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Latency: N+2 cycles from start to done (N=64, or 32 for *W); divide-by-zero/overflow take 2.
module ex_muldiv #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            md_op_i,
    input  logic                  word_i,
    input  logic [DATA_WIDTH-1:0] op_num1_i,
    input  logic [DATA_WIDTH-1:0] op_num2_i,
    input  logic [4:0]            addr_rd_i,
    input  logic                  flush_i,
    output logic                  hold_n_o,
    output logic                  done_o,
    output logic                  reg_wr_en_o,
    output logic [4:0]            addr_rd_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            word_q, s1_q, s2_q, spec_q;
    logic [4:0]      rd_q;
    logic [W-1:0]    a_q, hi_q, lo_q, result_q;

    // Operand preparation in the IDLE cycle
    logic            sgn1, sgn2, is_div, neg1, neg2, div_zero, div_ovf, special;
    logic [W-1:0]    op1_x, op2_x, mag1, mag2, min_neg, spec_val;

    assign sgn1    = (md_op_i == 3'd1) || (md_op_i == 3'd2) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    assign sgn2    = (md_op_i == 3'd1) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    assign is_div  = md_op_i[2];
    assign op1_x   = word_i ? {{(W-32){sgn1 & op_num1_i[31]}}, op_num1_i[31:0]} : op_num1_i;
    assign op2_x   = word_i ? {{(W-32){sgn2 & op_num2_i[31]}}, op_num2_i[31:0]} : op_num2_i;
    assign neg1    = sgn1 & op1_x[W-1];
    assign neg2    = sgn2 & op2_x[W-1];
    assign mag1    = neg1 ? (~op1_x + 1'b1) : op1_x;
    assign mag2    = neg2 ? (~op2_x + 1'b1) : op2_x;
    assign min_neg = word_i ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
    assign div_zero = is_div && (op2_x == '0);
    assign div_ovf  = is_div && sgn2 && (op1_x == min_neg) && (op2_x == '1);
    assign special  = div_zero || div_ovf;
    // md_op_i[1] distinguishes REM* from DIV*
    assign spec_val = div_zero ? (md_op_i[1] ? op1_x : '1) : (md_op_i[1] ? '0 : op1_x);

    // One CALC iteration
    logic [W:0]      mul_sum, rem_sh, rem_diff;
    logic [W-1:0]    hi_n, lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        rem_sh   = {hi_q, lo_q[W-1]};
        rem_diff = rem_sh - {1'b0, a_q};
        hi_n     = mul_sum[W:1];
        lo_n     = {mul_sum[0], lo_q[W-1:1]};
        if (op_q[2]) begin
            hi_n = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
            lo_n = {lo_q[W-2:0], ~rem_diff[W]};
        end
    end

    // Sign correction and result selection in FIX
    logic [2*W-1:0]  prod, prod_c;
    logic [W-1:0]    quo, quo_c, rem_c, res_raw, fix_res;

    always_comb begin
        prod   = word_q ? {{W{1'b0}}, hi_q[31:0], lo_q[W-1:32]} : {hi_q, lo_q};
        prod_c = (s1_q ^ s2_q) ? (~prod + 1'b1) : prod;
        quo    = word_q ? {{(W-32){1'b0}}, lo_q[31:0]} : lo_q;
        quo_c  = (s1_q ^ s2_q) ? (~quo + 1'b1) : quo;
        rem_c  = s1_q ? (~hi_q + 1'b1) : hi_q;
        case (op_q)
            3'd0:             res_raw = prod_c[W-1:0];
            3'd1, 3'd2, 3'd3: res_raw = prod_c[2*W-1:W];
            3'd4, 3'd5:       res_raw = quo_c;
            default:          res_raw = rem_c;
        endcase
        if (spec_q) res_raw = lo_q;
        fix_res = word_q ? {{(W-32){res_raw[31]}}, res_raw[31:0]} : res_raw;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = special ? FIX : CALC;
            CALC: if (cnt_q == CW'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            spec_q   <= 1'b0;
            rd_q     <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (!flush_i) begin
                case (state_q)
                    IDLE: if (start_i) begin
                        op_q   <= md_op_i;
                        word_q <= word_i;
                        rd_q   <= addr_rd_i;
                        spec_q <= special;
                        s1_q   <= neg1 & ~special;
                        s2_q   <= neg2 & ~special;
                        cnt_q  <= word_i ? CW'(32) : CW'(W);
                        a_q    <= is_div ? mag2 : mag1;
                        hi_q   <= '0;
                        // Divide shifts the dividend out MSB-first; word dividends are pre-aligned
                        if (special)     lo_q <= spec_val;
                        else if (is_div) lo_q <= word_i ? {mag1[31:0], {(W-32){1'b0}}} : mag1;
                        else             lo_q <= mag2;
                    end
                    CALC: begin
                        hi_q  <= hi_n;
                        lo_q  <= lo_n;
                        cnt_q <= cnt_q - CW'(1);
                    end
                    FIX:     result_q <= fix_res;
                    default: ;
                endcase
            end
        end
    end

    assign hold_n_o    = ~(((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC) || (state_q == FIX));
    assign done_o      = (state_q == DONE) && !flush_i;
    assign reg_wr_en_o = done_o && (rd_q != 5'd0);
    assign addr_rd_o   = rd_q;
    assign result_o    = result_q;

endmodule
